// File: rtl/reg_op_arbiter.sv
// Round-robin arbiter that shares the funsel/enable/data controls of a register bank among
// NREQ requesters, issuing INC/DEC repeat counts as back-to-back enable bursts.
module reg_op_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREG  = 4,
    parameter int unsigned NBITS = 16,
    parameter int unsigned CW    = 4,
    // One bit wider than a valid index so out-of-range targets can be requested and flagged.
    parameter int unsigned SW    = $clog2(NREG) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [NREQ*SW-1:0]    req_sel,
    input  logic [NREQ*NBITS-1:0] req_data,
    input  logic [NREQ*CW-1:0]    req_cnt,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [1:0]            reg_funsel,
    output logic [NREG-1:0]       reg_e,
    output logic [NBITS-1:0]      reg_i
);
    localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    rr_q, rr_d, win_q, win_d;
    logic [1:0]       op_q, op_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic [1:0]       funsel_q, funsel_d;
    logic [NREG-1:0]  reg_e_q, reg_e_d;
    logic [NBITS-1:0] reg_i_q, reg_i_d;

    logic [2*NREQ-1:0] req_rot;
    logic              found;
    logic [RW-1:0]     pick;
    logic [1:0]        pick_op;
    logic [SW-1:0]     pick_sel;
    logic [NBITS-1:0]  pick_data;
    logic [CW-1:0]     pick_cnt, pick_k;
    logic              pick_bad;

    always_comb begin
        // Rotate so bit 0 is the requester at the rr pointer; first set bit wins.
        req_rot = {req, req} >> rr_q;
        found   = 1'b0;
        pick    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                pick  = RW'((int'(rr_q) + i) % int'(NREQ));
            end
        end
        pick_op   = req_op[pick*2 +: 2];
        pick_sel  = req_sel[pick*SW +: SW];
        pick_data = req_data[pick*NBITS +: NBITS];
        pick_cnt  = req_cnt[pick*CW +: CW];
        pick_bad  = 32'(pick_sel) >= NREG;
        pick_k    = (pick_op[1] && !pick_bad && pick_cnt != '0) ? pick_cnt : CW'(1);
    end

    logic             beat, last;
    logic [1:0]       b_op;
    logic [SW-1:0]    b_sel;
    logic [NBITS-1:0] b_data;
    logic [RW-1:0]    b_win;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        win_d    = win_q;
        op_d     = op_q;
        sel_d    = sel_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        funsel_d = '0;
        reg_e_d  = '0;
        reg_i_d  = '0;
        beat     = 1'b0;
        last     = 1'b0;
        b_op     = op_q;
        b_sel    = sel_q;
        b_data   = data_q;
        b_win    = win_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StExec;
                    win_d   = pick;
                    op_d    = pick_op;
                    sel_d   = pick_sel;
                    data_d  = pick_data;
                    cnt_d   = pick_k;
                    beat    = 1'b1;
                    last    = (pick_k == CW'(1));
                    b_op    = pick_op;
                    b_sel   = pick_sel;
                    b_data  = pick_data;
                    b_win   = pick;
                end
            end
            StExec: begin
                // cnt_q counts beats still to show, including the one currently on the outputs.
                if (cnt_q == CW'(1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    beat  = 1'b1;
                    last  = (cnt_q == CW'(2));
                end
            end
            default: state_d = StIdle;
        endcase

        if (beat) begin
            funsel_d = b_op;
            reg_i_d  = b_data;
            for (int r = 0; r < NREG; r++) begin
                reg_e_d[r] = (32'(b_sel) == 32'(r));
            end
            if (last) begin
                ack_d[b_win] = 1'b1;
                err_d        = 32'(b_sel) >= NREG;
                rr_d         = (b_win == RW'(NREQ - 1)) ? '0 : b_win + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            win_q    <= '0;
            op_q     <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            funsel_q <= '0;
            reg_e_q  <= '0;
            reg_i_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            funsel_q <= funsel_d;
            reg_e_q  <= reg_e_d;
            reg_i_q  <= reg_i_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign reg_funsel = funsel_q;
    assign reg_e      = reg_e_q;
    assign reg_i      = reg_i_q;

endmodule

// File: tb/tb_reg_op_arbiter.sv
// Scoreboard bench for reg_op_arbiter: a timeline model of the arbiter predicts every output
// beat (cycle, enable, funsel, data, ack, err); a monitor compares what the DUT presents.
module tb_reg_op_arbiter;
    localparam int NREQ = 4, NREG = 4, NBITS = 16, CW = 4, SW = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_op;
    logic [NREQ*SW-1:0]    req_sel;
    logic [NREQ*NBITS-1:0] req_data;
    logic [NREQ*CW-1:0]    req_cnt;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [1:0]            reg_funsel;
    logic [NREG-1:0]       reg_e;
    logic [NBITS-1:0]      reg_i;

    reg_op_arbiter #(.NREQ(NREQ), .NREG(NREG), .NBITS(NBITS), .CW(CW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_sel(req_sel),
        .req_data(req_data), .req_cnt(req_cnt), .ack(ack), .err(err),
        .reg_funsel(reg_funsel), .reg_e(reg_e), .reg_i(reg_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [NREG-1:0]  e;
        logic [1:0]       fs;
        logic [NBITS-1:0] d;
        logic [NREQ-1:0]  ack;
        logic             err;
    } beat_t;

    beat_t sbq[$];
    int    checks = 0, errors = 0;
    int    edge_cnt = 0, next_arb = 0, rr = 0, grants = 0;
    bit    gen = 0, hold = 0, drop_mode = 0;
    bit    pend[NREQ], granted[NREQ], dropped[NREQ];
    int    ack_edge[NREQ];
    logic [1:0]       p_op[NREQ];
    logic [SW-1:0]    p_sel[NREQ];
    logic [NBITS-1:0] p_data[NREQ];
    logic [CW-1:0]    p_cnt[NREQ];
    logic [NBITS-1:0] bank[NREG];

    // Behavioural register bank driven by the DUT's control lines.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) bank[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (reg_e[r]) begin
                    case (reg_funsel)
                        2'b00:   bank[r] <= '0;
                        2'b01:   bank[r] <= reg_i;
                        2'b10:   bank[r] <= bank[r] - 1'b1;
                        default: bank[r] <= bank[r] + 1'b1;
                    endcase
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]                   = pend[i] && !dropped[i];
            req_op[i*2 +: 2]         = p_op[i];
            req_sel[i*SW +: SW]      = p_sel[i];
            req_data[i*NBITS +: NBITS] = p_data[i];
            req_cnt[i*CW +: CW]      = p_cnt[i];
        end
    endtask

    task automatic new_payload(int i);
        p_op[i]   = 2'($urandom);
        p_sel[i]  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        p_data[i] = 16'($urandom);
        p_cnt[i]  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
    endtask

    task automatic add_req(int i, logic [1:0] op, logic [SW-1:0] sel, logic [NBITS-1:0] d,
                           logic [CW-1:0] c);
        pend[i] = 1; dropped[i] = 0;
        p_op[i] = op; p_sel[i] = sel; p_data[i] = d; p_cnt[i] = c;
        drive();
    endtask

    // At an arbitration edge the winner's k beats occupy the next k cycles, then one idle cycle.
    task automatic model_edge();
        int    w, k;
        bit    bad;
        beat_t b;
        if (edge_cnt >= next_arb && req != '0) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) if (w < 0 && req[(rr + j) % NREQ]) w = (rr + j) % NREQ;
            bad = int'(p_sel[w]) >= NREG;
            k   = (bad || !p_op[w][1] || p_cnt[w] == 0) ? 1 : int'(p_cnt[w]);
            for (int j = 0; j < k; j++) begin
                b.cyc = edge_cnt + j;
                b.e   = bad ? '0 : NREG'(1) << p_sel[w];
                b.fs  = p_op[w];
                b.d   = p_data[w];
                b.ack = (j == k - 1) ? NREQ'(1) << w : '0;
                b.err = (j == k - 1) && bad;
                sbq.push_back(b);
            end
            next_arb    = edge_cnt + k + 1;
            rr          = (w + 1) % NREQ;
            granted[w]  = 1;
            ack_edge[w] = edge_cnt + k - 1;
            grants++;
        end
    endtask

    task automatic update_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (granted[i] && ack_edge[i] == edge_cnt) begin
                granted[i] = 0; dropped[i] = 0;
                pend[i] = hold || (gen && $urandom_range(0, 3) == 0);
                if (pend[i] && !hold) new_payload(i);
            end else if (granted[i]) begin
                if (!dropped[i] && (drop_mode || (gen && $urandom_range(0, 7) == 0))) begin
                    dropped[i] = 1;
                    new_payload(i);
                end
            end else if (!pend[i] && gen && $urandom_range(0, 2) == 0) begin
                pend[i] = 1;
                new_payload(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_cnt++;
        if (rst_n) model_edge();
        @(negedge clk);
        update_reqs();
        drive();
    endtask

    function automatic bit busy();
        busy = sbq.size() != 0;
        for (int i = 0; i < NREQ; i++) if (pend[i]) busy = 1;
    endfunction

    task automatic run_until_idle(int budget, string name);
        int n = 0;
        while (busy() && n < budget) begin step(); n++; end
        if (busy()) begin
            checks++; errors++;
            $display("FAIL %s: still busy after %0d cycles, want idle", name, budget);
        end
        step(); step();
    endtask

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sbq.size() > 0 && sbq[0].cyc < edge_cnt) begin
                    e = sbq.pop_front(); checks++; errors++;
                    $display("FAIL missing_beat: got nothing at cycle %0d, want e=%b fs=%b d=%h ack=%b err=%b",
                             e.cyc, e.e, e.fs, e.d, e.ack, e.err);
                end
                if (reg_e != '0 || ack != '0 || err) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got e=%b ack=%b err=%b at cycle %0d, want idle",
                                 reg_e, ack, err, edge_cnt);
                    end else begin
                        e = sbq.pop_front();
                        if (e.cyc != edge_cnt || reg_e !== e.e || reg_funsel !== e.fs ||
                            reg_i !== e.d || ack !== e.ack || err !== e.err) begin
                            errors++;
                            $display("FAIL beat: got cyc=%0d e=%b fs=%b d=%h ack=%b err=%b, want cyc=%0d e=%b fs=%b d=%h ack=%b err=%b",
                                     edge_cnt, reg_e, reg_funsel, reg_i, ack, err,
                                     e.cyc, e.e, e.fs, e.d, e.ack, e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n, target;
        rst_n = 0; req = '0; req_op = '0; req_sel = '0; req_data = '0; req_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; granted[i] = 0; dropped[i] = 0; ack_edge[i] = 0;
            p_op[i] = '0; p_sel[i] = '0; p_data[i] = '0; p_cnt[i] = '0;
        end
        drive();
        repeat (3) step();
        checks++;
        if (reg_e !== '0 || reg_funsel !== '0 || reg_i !== '0 || ack !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got e=%b fs=%b d=%h ack=%b err=%b, want all zero",
                     reg_e, reg_funsel, reg_i, ack, err);
        end
        rst_n = 1;

        add_req(0, 2'b01, 3'd2, 16'h00A5, 4'd0);
        run_until_idle(20, "load");

        add_req(1, 2'b11, 3'd1, 16'h0000, 4'd5);
        run_until_idle(20, "inc5");
        checks++;
        if (bank[1][3:0] !== 4'd5) begin
            errors++;
            $display("FAIL inc_bank: got %0d, want 5", bank[1][3:0]);
        end

        hold = 1;
        for (int i = 0; i < NREQ; i++) add_req(i, 2'b00, 3'(i), 16'h0, 4'd0);
        target = grants + 5; n = 0;
        while (grants < target && n < 100) begin step(); n++; end
        hold = 0;
        run_until_idle(50, "clr_rr");

        add_req(2, 2'b10, 3'd0, 16'h0000, 4'd0);
        add_req(3, 2'b11, 3'd7, 16'h1234, 4'd5);
        run_until_idle(30, "dec0_badsel");

        drop_mode = 1;
        add_req(1, 2'b10, 3'd3, 16'h0005, 4'd3);
        run_until_idle(30, "drop");
        drop_mode = 0;

        gen = 1;
        repeat (1500) step();
        gen = 0;
        run_until_idle(300, "drain");

        // Leave rr at 2, then reset in the third beat of an 8-beat burst.
        add_req(1, 2'b00, 3'd0, 16'h0, 4'd0);
        run_until_idle(20, "pre_reset");
        add_req(2, 2'b11, 3'd0, 16'h0, 4'd8);
        n = 0;
        while (!granted[2] && n < 20) begin step(); n++; end
        step(); step();
        #1 rst_n = 0;
        #1;
        checks++;
        if (reg_e !== '0 || ack !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got e=%b ack=%b err=%b, want all zero", reg_e, ack, err);
        end
        sbq.delete();
        rr = 0; next_arb = 0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; granted[i] = 0; dropped[i] = 0; end
        drive();
        step();
        checks++;
        if (reg_e !== '0 || ack !== '0) begin
            errors++;
            $display("FAIL reset_hold: got e=%b ack=%b, want zero", reg_e, ack);
        end
        step();
        rst_n = 1;
        add_req(3, 2'b01, 3'd3, 16'hBEEF, 4'd0);
        add_req(0, 2'b01, 3'd0, 16'hCAFE, 4'd0);
        run_until_idle(20, "post_reset");

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d beats outstanding, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
